// File: rtl/fifo_array_drain.sv
// fifo_array_drain: round-robin burst reader for a multi-channel FIFO array feeding a registered valid/ready stream.
// Define FIFO_DRAIN_STATS_EN to add the pop_cnt_o and idle_scan_o statistics outputs.
module fifo_array_drain #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  output logic [$clog2(N_CH)-1:0] ch_id_o,
  input  logic                    empty_i,
  output logic                    rden_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic [$clog2(N_CH)-1:0] m_ch_o
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0]             pop_cnt_o,
  output logic                    idle_scan_o
`endif
);
  localparam int CW = $clog2(N_CH);
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic {SCAN, SERVE} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         ptr_q, ptr_d, ptr_nxt;
  logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [CW-1:0]         m_ch_q;
  logic                  slot_free, pop, last;
  assign ch_id_o   = ptr_q;
  assign rden_o    = pop;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_ch_o    = m_ch_q;
  always_comb begin
    slot_free   = !m_valid_q || m_ready_i;
    pop         = state_q == SERVE && en_i && !empty_i && slot_free;
    last        = burst_cnt_q == BW'(MAX_BURST - 1);
    ptr_nxt     = ptr_q == CW'(N_CH - 1) ? '0 : ptr_q + 1'b1;
    m_valid_d   = pop ? 1'b1 : m_ready_i ? 1'b0 : m_valid_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == SCAN) begin
      if (en_i && !empty_i) begin
        state_d     = SERVE;
        burst_cnt_d = '0;
      end else if (en_i) begin
        ptr_d = ptr_nxt;
      end
    end else if (!en_i) begin
      state_d     = SCAN;
      burst_cnt_d = '0;
    end else if (empty_i) begin
      state_d     = SCAN;
      ptr_d       = ptr_nxt;
      burst_cnt_d = '0;
    end else if (pop) begin
      // the final pop of a visit hands the select to the next channel
      state_d     = last ? SCAN : SERVE;
      ptr_d       = last ? ptr_nxt : ptr_q;
      burst_cnt_d = last ? '0 : burst_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ch_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      m_valid_q   <= m_valid_d;
      if (pop) begin
        m_data_q <= rdata_i;
        m_ch_q   <= ptr_q;
      end
    end
  end
`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] pop_cnt_q;
  logic        idle_scan_q;
  assign pop_cnt_o   = pop_cnt_q;
  assign idle_scan_o = idle_scan_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_cnt_q   <= '0;
      idle_scan_q <= 1'b0;
    end else begin
      pop_cnt_q   <= pop_cnt_q + 32'(pop);
      idle_scan_q <= state_q == SCAN && en_i && empty_i;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_array_drain.sv
// tb_fifo_array_drain: queue-based FIFO array mock and per-channel order scoreboard around fifo_array_drain (N_CH=3).
module tb_fifo_array_drain;
  localparam int N = 3, DW = 16, MB = 4, CW = 2;
  logic clk = 0, rst_n = 0, en_i = 0, empty_i = 1, rden_o, m_valid_o, m_ready_i = 0;
  logic [CW-1:0] ch_id_o, m_ch_o;
  logic [DW-1:0] rdata_i = '0, m_data_o;
`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] pop_cnt_o;
  logic        idle_scan_o;
`endif
  fifo_array_drain #(.N_CH(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .ch_id_o(ch_id_o), .empty_i(empty_i),
    .rden_o(rden_o), .rdata_i(rdata_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_ch_o(m_ch_o)
`ifdef FIFO_DRAIN_STATS_EN
    , .pop_cnt_o(pop_cnt_o), .idle_scan_o(idle_scan_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; int ch; logic [DW-1:0] d;} out_t;
  logic [DW-1:0] fq [N][$];
  logic [DW-1:0] ref_q [N][$];
  out_t outs[$];
  int pops[$], ptrs[$];
  int cyc, viol, tests, fails;
  logic hold_v;
  logic [DW-1:0] hold_d;
  logic [CW-1:0] hold_c;
  task automatic refresh();
    int c = int'(ch_id_o);
    if (c < N && fq[c].size() > 0) begin
      empty_i = 0;
      rdata_i = fq[c][0];
    end else begin
      empty_i = 1;
      rdata_i = DW'($urandom);
    end
  endtask
  task automatic push(int ch, logic [DW-1:0] v);
    fq[ch].push_back(v);
    ref_q[ch].push_back(v);
  endtask
  task automatic clear_logs();
    outs.delete(); pops.delete(); ptrs.delete();
    cyc = 0; viol = 0; hold_v = 0;
  endtask
  task automatic tick();
    logic p;
    int c;
    @(negedge clk);
    refresh();
    #1;
    if (rden_o && empty_i) viol++;
    if (hold_v && (m_data_o !== hold_d || m_ch_o !== hold_c)) viol++;
    if (m_valid_o && m_ready_i) outs.push_back('{cyc, int'(m_ch_o), m_data_o});
    hold_v = m_valid_o && !m_ready_i;
    hold_d = m_data_o;
    hold_c = m_ch_o;
    ptrs.push_back(int'(ch_id_o));
    pops.push_back(rden_o ? int'(ch_id_o) : -1);
    p = rden_o;
    c = int'(ch_id_o);
    @(posedge clk);
    #1;
    if (p && c < N) void'(fq[c].pop_front());
    cyc++;
  endtask
  task automatic do_reset();
    rst_n = 0; en_i = 0; m_ready_i = 0;
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      ref_q[i].delete();
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clear_logs();
  endtask
  task automatic test_reset();
    rst_n = 0;
    #1;
    tests++; if (m_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", m_valid_o); end
    tests++; if (rden_o !== 1'b0) begin fails++; $display("FAIL reset_rden got %b exp 0", rden_o); end
    tests++; if (ch_id_o !== '0) begin fails++; $display("FAIL reset_ch_id got %0d exp 0", ch_id_o); end
    tests++; if (m_data_o !== '0 || m_ch_o !== '0) begin fails++; $display("FAIL reset_data got %h/%0d exp 0/0", m_data_o, m_ch_o); end
`ifdef FIFO_DRAIN_STATS_EN
    tests++; if (pop_cnt_o !== 32'd0) begin fails++; $display("FAIL reset_pop_cnt got %0d exp 0", pop_cnt_o); end
`endif
    do_reset();
  endtask
  task automatic test_scan_empty();
    int eptr[7] = '{0, 1, 2, 0, 1, 2, 0};
    do_reset();
    en_i = 1; m_ready_i = 1;
    repeat (7) tick();
    for (int i = 0; i < 7; i++) begin
      tests++; if (ptrs[i] !== eptr[i] || pops[i] !== -1) begin fails++; $display("FAIL scan_empty[%0d] got ptr %0d pop %0d exp ptr %0d pop -1", i, ptrs[i], pops[i], eptr[i]); end
    end
    tests++; if (outs.size() !== 0 || m_valid_o !== 1'b0) begin fails++; $display("FAIL scan_empty_out got %0d words exp 0", outs.size()); end
`ifdef FIFO_DRAIN_STATS_EN
    tests++; if (idle_scan_o !== 1'b1) begin fails++; $display("FAIL idle_scan got %b exp 1", idle_scan_o); end
`endif
  endtask
  task automatic test_ch2_burst();
    int ep[8] = '{-1, -1, -1, 2, 2, 2, -1, -1};
    int eptr[8] = '{0, 1, 2, 2, 2, 2, 2, 0};
    logic [DW-1:0] ed[3] = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
    do_reset();
    for (int i = 0; i < 3; i++) push(2, ed[i]);
    en_i = 1; m_ready_i = 1;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      tests++; if (ptrs[i] !== eptr[i] || pops[i] !== ep[i]) begin fails++; $display("FAIL ch2_trace[%0d] got ptr %0d pop %0d exp ptr %0d pop %0d", i, ptrs[i], pops[i], eptr[i], ep[i]); end
    end
    tests++; if (outs.size() !== 3) begin fails++; $display("FAIL ch2_count got %0d exp 3", outs.size()); end
    for (int i = 0; i < 3 && i < outs.size(); i++) begin
      tests++; if (outs[i].d !== ed[i] || outs[i].ch !== 2 || outs[i].cyc !== 4 + i) begin fails++; $display("FAIL ch2_out[%0d] got %h ch%0d @%0d exp %h ch2 @%0d", i, outs[i].d, outs[i].ch, outs[i].cyc, ed[i], 4 + i); end
    end
  endtask
  task automatic test_burst_limit();
    int ep[11] = '{-1, 0, 0, 0, 0, -1, -1, -1, 0, 0, -1};
    int eptr[11] = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0};
    int ec[6] = '{2, 3, 4, 5, 9, 10};
    do_reset();
    for (int i = 0; i < 6; i++) push(0, DW'(16'h0100 + i));
    en_i = 1; m_ready_i = 1;
    repeat (11) tick();
    for (int i = 0; i < 11; i++) begin
      tests++; if (ptrs[i] !== eptr[i] || pops[i] !== ep[i]) begin fails++; $display("FAIL burst_trace[%0d] got ptr %0d pop %0d exp ptr %0d pop %0d", i, ptrs[i], pops[i], eptr[i], ep[i]); end
    end
    tests++; if (outs.size() !== 6) begin fails++; $display("FAIL burst_count got %0d exp 6", outs.size()); end
    for (int i = 0; i < 6 && i < outs.size(); i++) begin
      tests++; if (outs[i].d !== DW'(16'h0100 + i) || outs[i].ch !== 0 || outs[i].cyc !== ec[i]) begin fails++; $display("FAIL burst_out[%0d] got %h ch%0d @%0d exp %h ch0 @%0d", i, outs[i].d, outs[i].ch, outs[i].cyc, 16'h0100 + i, ec[i]); end
    end
  endtask
  task automatic test_stall();
    int ep[10] = '{-1, -1, 1, -1, -1, -1, -1, -1, 1, -1};
    do_reset();
    push(1, 16'h5A5A); push(1, 16'hC3C3);
    en_i = 1;
    for (int c = 0; c < 10; c++) begin
      m_ready_i = !(c >= 3 && c <= 7);
      if (c == 6) begin
        #1;
        tests++; if (m_valid_o !== 1'b1 || m_data_o !== 16'h5A5A || m_ch_o !== 2'd1 || rden_o !== 1'b0) begin fails++; $display("FAIL stall_hold got v%b %h ch%0d rden%b exp v1 5a5a ch1 rden0", m_valid_o, m_data_o, m_ch_o, rden_o); end
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      tests++; if (pops[i] !== ep[i]) begin fails++; $display("FAIL stall_pop[%0d] got %0d exp %0d", i, pops[i], ep[i]); end
    end
    tests++; if (outs.size() !== 2) begin fails++; $display("FAIL stall_count got %0d exp 2", outs.size()); end
    else begin
      tests++; if (outs[0].d !== 16'h5A5A || outs[0].cyc !== 8 || outs[1].d !== 16'hC3C3 || outs[1].cyc !== 9) begin fails++; $display("FAIL stall_out got %h@%0d %h@%0d exp 5a5a@8 c3c3@9", outs[0].d, outs[0].cyc, outs[1].d, outs[1].cyc); end
    end
    tests++; if (viol !== 0) begin fails++; $display("FAIL stall_stable got %0d violations exp 0", viol); end
  endtask
  task automatic test_wrap_all();
    int ep[10] = '{-1, 0, -1, -1, 1, -1, -1, 2, -1, -1};
    int eptr[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    do_reset();
    for (int i = 0; i < N; i++) push(i, DW'(16'h7000 + i));
    en_i = 1; m_ready_i = 1;
    repeat (10) tick();
    for (int i = 0; i < 10; i++) begin
      tests++; if (ptrs[i] !== eptr[i] || pops[i] !== ep[i]) begin fails++; $display("FAIL wrap_trace[%0d] got ptr %0d pop %0d exp ptr %0d pop %0d", i, ptrs[i], pops[i], eptr[i], ep[i]); end
    end
    tests++; if (outs.size() !== N) begin fails++; $display("FAIL wrap_count got %0d exp %0d", outs.size(), N); end
    for (int i = 0; i < N && i < outs.size(); i++) begin
      tests++; if (outs[i].ch !== i || outs[i].d !== DW'(16'h7000 + i)) begin fails++; $display("FAIL wrap_out[%0d] got ch%0d %h exp ch%0d %h", i, outs[i].ch, outs[i].d, i, 16'h7000 + i); end
    end
  endtask
  task automatic test_reset_midburst();
    do_reset();
    for (int i = 0; i < 8; i++) push(1, DW'(100 + i));
    en_i = 1; m_ready_i = 1;
    repeat (4) tick();
    refresh();
    #1;
    tests++; if (rden_o !== 1'b1 || m_valid_o !== 1'b1) begin fails++; $display("FAIL midburst_pre got rden%b v%b exp 1/1", rden_o, m_valid_o); end
    rst_n = 0;
    #1;
    tests++; if (m_valid_o !== 1'b0 || rden_o !== 1'b0 || ch_id_o !== '0) begin fails++; $display("FAIL midburst_rst got v%b rden%b ch%0d exp 0/0/0", m_valid_o, rden_o, ch_id_o); end
`ifdef FIFO_DRAIN_STATS_EN
    tests++; if (pop_cnt_o !== 32'd0) begin fails++; $display("FAIL midburst_pop_cnt got %0d exp 0", pop_cnt_o); end
`endif
    @(posedge clk);
    #1 rst_n = 1;
    clear_logs();
    repeat (4) tick();
    tests++; if (ptrs[0] !== 0 || ptrs[1] !== 1 || pops[1] !== -1 || pops[2] !== 1) begin fails++; $display("FAIL midburst_restart got ptr %0d,%0d pop %0d,%0d exp 0,1 -1,1", ptrs[0], ptrs[1], pops[1], pops[2]); end
    tests++; if (outs.size() < 1 || outs[0].d !== DW'(102)) begin fails++; $display("FAIL midburst_word got %0d words first %h exp %h", outs.size(), outs.size() ? outs[0].d : '0, 102); end
  endtask
  task automatic test_random();
    int run = 0, lastp = -1, guard = 0, npop = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, N - 1)), DW'($urandom));
      m_ready_i = $urandom_range(0, 9) < 7;
      en_i = $urandom_range(0, 19) != 0;
      tick();
      if (!en_i || ptrs[$] != lastp) run = 0;
      lastp = ptrs[$];
      if (pops[$] >= 0) begin
        run++; npop++;
        tests++; if (run > MB) begin fails++; $display("FAIL rand_burst got run %0d exp <= %0d", run, MB); end
      end
    end
    en_i = 1; m_ready_i = 1;
    while ((fq[0].size() + fq[1].size() + fq[2].size() > 0 || m_valid_o) && guard < 300) begin
      tick();
      if (pops[$] >= 0) npop++;
      guard++;
    end
    tests++; if (guard >= 300) begin fails++; $display("FAIL rand_drain got timeout after %0d cycles exp drained", guard); end
    foreach (outs[i]) begin
      logic [DW-1:0] e;
      e = (outs[i].ch < N && ref_q[outs[i].ch].size() > 0) ? ref_q[outs[i].ch].pop_front() : ~outs[i].d;
      tests++; if (outs[i].d !== e) begin fails++; $display("FAIL rand_out[%0d] got %h ch%0d exp %h", i, outs[i].d, outs[i].ch, e); end
    end
    tests++; if (ref_q[0].size() + ref_q[1].size() + ref_q[2].size() != 0) begin fails++; $display("FAIL rand_lost got %0d words left exp 0", ref_q[0].size() + ref_q[1].size() + ref_q[2].size()); end
    tests++; if (viol !== 0) begin fails++; $display("FAIL rand_protocol got %0d violations exp 0", viol); end
`ifdef FIFO_DRAIN_STATS_EN
    tests++; if (pop_cnt_o !== 32'(npop)) begin fails++; $display("FAIL rand_pop_cnt got %0d exp %0d", pop_cnt_o, npop); end
`endif
  endtask
  initial begin
    tests = 0; fails = 0;
    clear_logs();
    test_reset();
    test_scan_empty();
    test_ch2_burst();
    test_burst_limit();
    test_stall();
    test_wrap_all();
    test_reset_midburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
